simd_mul_and: RTL and testbench

SIMD lane-wise multiply / AND unit in the correlated-random-generator datapath. Combines two 256-bit PRNG words under one of two modes: arithmetic (lane-wise full multiply) or Boolean (half-adder XOR/AND). It has a fixed 9-stage pipeline with no handshake, and it feeds downstream accumulation logic with a two-word result (`ps_o`, `sc_o`).

---
 rtl/simd_mul_and.sv | 181 ++++++++++++++++++
 tb/tb_simd_mul_and.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_mul_and.sv
// SIMD lane-wise multiply / Boolean half-adder unit, 9 register stages, one result per clock.
// Define SIMD_MULAND_BOOL_EN to build the Boolean (XOR/AND) mode; otherwise mode 010 yields zeros.
module simd_mul_and #(
  parameter int W = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [2:0]   mode_i,
  input  logic [2:0]   width_i,
  output logic [W-1:0] ps_o,
  output logic [W-1:0] sc_o
);

  localparam int NL = W / 32;
  localparam int AW = 2 * W;
  localparam logic [2:0] MODE_A = 3'b100;
  localparam logic [2:0] MODE_B = 3'b010;

  // log2 of lane size in 32-bit limbs; unknown width codes fall back to 32-bit lanes
  function automatic logic [1:0] lane_shift(input logic [2:0] wid);
    case (wid)
      3'b001:  lane_shift = 2'd1;
      3'b011:  lane_shift = 2'd2;
      3'b111:  lane_shift = 2'd3;
      default: lane_shift = 2'd0;
    endcase
  endfunction

  logic [W-1:0]  r_x1;
  logic [W-1:0]  r_y1;
  logic [2:0]    r_mode [1:6];
  logic [2:0]    r_wid  [1:6];
  logic [63:0]   r_pp   [NL][NL];
  logic [AW-1:0] r_row  [NL];
  logic [AW-1:0] r_s4   [4];
  logic [AW-1:0] r_s5   [2];
  logic [AW-1:0] r_acc6;
  logic [W-1:0]  r_ps7, r_sc7, r_ps8, r_sc8;

  logic [1:0]    w_sh1, w_sh6;
  logic [63:0]   w_pp  [NL][NL];
  logic [AW-1:0] w_row [NL];
  logic [W-1:0]  w_mul_ps, w_mul_sc, w_ps7, w_sc7;

  assign w_sh1 = lane_shift(r_wid[1]);
  assign w_sh6 = lane_shift(r_wid[6]);

  // input register and control pipeline (mode/width travel with their data)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x1 <= '0;
      r_y1 <= '0;
      for (int k = 1; k <= 6; k++) begin
        r_mode[k] <= '0;
        r_wid[k]  <= '0;
      end
    end else begin
      r_x1      <= x_i;
      r_y1      <= y_i;
      r_mode[1] <= mode_i;
      r_wid[1]  <= width_i;
      for (int k = 2; k <= 6; k++) begin
        r_mode[k] <= r_mode[k-1];
        r_wid[k]  <= r_wid[k-1];
      end
    end
  end

  // 32x32 limb products; products pairing limbs from different lanes are forced to zero
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      for (int j = 0; j < NL; j++) begin
        w_pp[i][j] = '0;
        if ((i >> w_sh1) == (j >> w_sh1))
          w_pp[i][j] = 64'(r_x1[32*i +: 32]) * 64'(r_y1[32*j +: 32]);
      end
    end
  end

  // Placing pp[i][j] at limb i+j lays lane k's 2w-bit product at bits [k*2w +: 2w],
  // so partial sums of one lane can never spill into the next.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      w_row[i] = '0;
      for (int j = 0; j < NL; j++)
        w_row[i] = w_row[i] + ({{(AW-64){1'b0}}, r_pp[i][j]} << (32 * (i + j)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NL; i++) begin
        for (int j = 0; j < NL; j++)
          r_pp[i][j] <= '0;
        r_row[i] <= '0;
      end
      for (int k = 0; k < 4; k++) r_s4[k] <= '0;
      for (int k = 0; k < 2; k++) r_s5[k] <= '0;
      r_acc6 <= '0;
    end else begin
      r_pp <= w_pp;
      for (int i = 0; i < NL; i++) r_row[i] <= w_row[i];
      for (int k = 0; k < 4; k++) r_s4[k] <= r_row[2*k] + r_row[2*k+1];
      for (int k = 0; k < 2; k++) r_s5[k] <= r_s4[2*k] + r_s4[2*k+1];
      r_acc6 <= r_s5[0] + r_s5[1];
    end
  end

  // unpack: limb l with lane offset o reads low half at acc limb 2l-o, high half m limbs above
  always_comb begin
    int m;
    int o;
    int idx;
    m = 1 << w_sh6;
    w_mul_ps = '0;
    w_mul_sc = '0;
    for (int l = 0; l < NL; l++) begin
      o   = l & (m - 1);
      idx = 2 * l - o;
      w_mul_ps[32*l +: 32] = r_acc6[32*idx +: 32];
      w_mul_sc[32*l +: 32] = r_acc6[32*(idx + m) +: 32];
    end
  end

`ifdef SIMD_MULAND_BOOL_EN
  logic [W-1:0] r_bps [2:6];
  logic [W-1:0] r_bsc [2:6];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 2; k <= 6; k++) begin
        r_bps[k] <= '0;
        r_bsc[k] <= '0;
      end
    end else begin
      r_bps[2] <= r_x1 ^ r_y1;
      r_bsc[2] <= r_x1 & r_y1;
      for (int k = 3; k <= 6; k++) begin
        r_bps[k] <= r_bps[k-1];
        r_bsc[k] <= r_bsc[k-1];
      end
    end
  end
`endif

  always_comb begin
    w_ps7 = '0;
    w_sc7 = '0;
    if (r_mode[6] == MODE_A) begin
      w_ps7 = w_mul_ps;
      w_sc7 = w_mul_sc;
    end
`ifdef SIMD_MULAND_BOOL_EN
    else if (r_mode[6] == MODE_B) begin
      w_ps7 = r_bps[6];
      w_sc7 = r_bsc[6];
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ps7 <= '0;
      r_sc7 <= '0;
      r_ps8 <= '0;
      r_sc8 <= '0;
      ps_o  <= '0;
      sc_o  <= '0;
    end else begin
      r_ps7 <= w_ps7;
      r_sc7 <= w_sc7;
      r_ps8 <= r_ps7;
      r_sc8 <= r_sc7;
      ps_o  <= r_ps8;
      sc_o  <= r_sc8;
    end
  end

endmodule

// File: tb/tb_simd_mul_and.sv
// Self-checking bench for simd_mul_and: directed corner vectors plus a randomized stream
// compared against a lane-arithmetic reference model delayed through a 9-entry queue.
module tb_simd_mul_and;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic [255:0] x_i = '0;
  logic [255:0] y_i = '0;
  logic [2:0]   mode_i = '0;
  logic [2:0]   width_i = '0;
  logic [255:0] ps_o;
  logic [255:0] sc_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] q_ps [$];
  logic [255:0] q_sc [$];
  logic [255:0] exp_ps, exp_sc;

  simd_mul_and #(.W(256)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .x_i     (x_i),
    .y_i     (y_i),
    .mode_i  (mode_i),
    .width_i (width_i),
    .ps_o    (ps_o),
    .sc_o    (sc_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model(input logic [255:0] x, input logic [255:0] y,
                                input logic [2:0] mode, input logic [2:0] width,
                                output logic [255:0] ps, output logic [255:0] sc);
    int w;
    logic [511:0] mask, xl, yl, p;
    case (width)
      3'b001:  w = 64;
      3'b011:  w = 128;
      3'b111:  w = 256;
      default: w = 32;
    endcase
    ps = '0;
    sc = '0;
    if (mode == 3'b100) begin
      mask = (512'd1 << w) - 512'd1;
      for (int k = 0; k < 256 / w; k++) begin
        xl = ({256'd0, x} >> (k * w)) & mask;
        yl = ({256'd0, y} >> (k * w)) & mask;
        p  = xl * yl;
        ps = ps | 256'((p & mask) << (k * w));
        sc = sc | 256'(((p >> w) & mask) << (k * w));
      end
    end
`ifdef SIMD_MULAND_BOOL_EN
    else if (mode == 3'b010) begin
      ps = x ^ y;
      sc = x & y;
    end
`endif
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    if ($urandom_range(0, 15) == 0) r = '1;
    return r;
  endfunction

  function automatic logic [2:0] rnd_mode();
    case ($urandom_range(0, 7))
      0, 1, 2: return 3'b100;
      3, 4:    return 3'b010;
      5:       return 3'b000;
      6:       return 3'b001;
      default: return 3'($urandom);
    endcase
  endfunction

  function automatic logic [2:0] rnd_width();
    case ($urandom_range(0, 4))
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      3:       return 3'b111;
      default: return 3'($urandom);
    endcase
  endfunction

  task automatic reset_model();
    q_ps.delete();
    q_sc.delete();
    repeat (9) begin
      q_ps.push_back('0);
      q_sc.push_back('0);
    end
  endtask

  // one clock edge with reset low; the model queue delivers what the outputs must show after it
  task automatic step();
    logic [255:0] mp, ms;
    @(posedge clk_i);
    model(x_i, y_i, mode_i, width_i, mp, ms);
    q_ps.push_back(mp);
    q_sc.push_back(ms);
    while (q_ps.size() > 9) begin
      void'(q_ps.pop_front());
      void'(q_sc.pop_front());
    end
    #1;
    exp_ps = q_ps[0];
    exp_sc = q_sc[0];
  endtask

  task automatic run_vec(input logic [255:0] x, input logic [255:0] y,
                         input logic [2:0] m, input logic [2:0] w);
    x_i = x; y_i = y; mode_i = m; width_i = w;
    step();
    x_i = rnd256(); y_i = rnd256(); mode_i = 3'b000; width_i = 3'($urandom);
    repeat (8) step();
  endtask

  task automatic test_reset();
    #3 rst_i = 1'b1;
    #1;
    n_checks++;
    if (ps_o !== '0 || sc_o !== '0) begin
      n_fail++;
      $display("FAIL reset_async ps=%h sc=%h want 0", ps_o, sc_o);
    end
    for (int c = 0; c < 3; c++) begin
      x_i = rnd256(); y_i = rnd256(); mode_i = 3'b100; width_i = 3'b111;
      @(posedge clk_i);
      #1;
      n_checks++;
      if (ps_o !== '0 || sc_o !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d ps=%h sc=%h want 0", c, ps_o, sc_o);
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    reset_model();
  endtask

  task automatic test_mode_a();
    logic [255:0] tx [7], ty [7], eps [7], esc [7];
    logic [2:0]   tw [7];
    tx[0] = {8{32'hFFFFFFFF}}; ty[0] = {8{32'h00000002}}; tw[0] = 3'b000;
    eps[0] = {8{32'hFFFFFFFE}}; esc[0] = {8{32'h00000001}};
    tx[1] = {1'b1, 255'd0}; ty[1] = 256'd2; tw[1] = 3'b111;
    eps[1] = 256'd0; esc[1] = 256'd1;
    tx[2] = '1; ty[2] = '1; tw[2] = 3'b111;
    eps[2] = 256'd1; esc[2] = {{255{1'b1}}, 1'b0};
    tx[3] = '1; ty[3] = '1; tw[3] = 3'b001;
    eps[3] = {4{64'd1}}; esc[3] = {4{64'hFFFFFFFFFFFFFFFE}};
    tx[4] = '1; ty[4] = '1; tw[4] = 3'b011;
    eps[4] = {2{128'd1}}; esc[4] = {2{{127{1'b1}}, 1'b0}};
    tx[5] = '1; ty[5] = '1; tw[5] = 3'b000;
    eps[5] = {8{32'd1}}; esc[5] = {8{32'hFFFFFFFE}};
    tx[6] = '1; ty[6] = '1; tw[6] = 3'b010;
    eps[6] = {8{32'd1}}; esc[6] = {8{32'hFFFFFFFE}};
    for (int t = 0; t < 7; t++) begin
      run_vec(tx[t], ty[t], 3'b100, tw[t]);
      n_checks++;
      if (ps_o !== eps[t] || sc_o !== esc[t]) begin
        n_fail++;
        $display("FAIL mode_a_vec%0d ps=%h sc=%h want ps=%h sc=%h", t, ps_o, sc_o, eps[t], esc[t]);
      end
    end
  endtask

  task automatic test_mode_b();
    logic [255:0] xb, yb, want_ps, want_sc;
    xb = {32{8'hF0}};
    yb = {16{16'hFF00}};
`ifdef SIMD_MULAND_BOOL_EN
    want_ps = {16{16'h0FF0}};
    want_sc = {16{16'hF000}};
`else
    want_ps = '0;
    want_sc = '0;
`endif
    for (int w = 0; w < 8; w++) begin
      run_vec(xb, yb, 3'b010, 3'(w));
      n_checks++;
      if (ps_o !== want_ps || sc_o !== want_sc) begin
        n_fail++;
        $display("FAIL mode_b_w%0d ps=%h sc=%h want ps=%h sc=%h", w, ps_o, sc_o, want_ps, want_sc);
      end
    end
  endtask

  task automatic test_invalid_mode();
    logic [2:0] bad [6];
    bad[0] = 3'b001; bad[1] = 3'b000; bad[2] = 3'b011;
    bad[3] = 3'b101; bad[4] = 3'b110; bad[5] = 3'b111;
    for (int t = 0; t < 6; t++) begin
      run_vec(rnd256(), rnd256(), bad[t], rnd_width());
      n_checks++;
      if (ps_o !== '0 || sc_o !== '0) begin
        n_fail++;
        $display("FAIL invalid_mode_%b ps=%h sc=%h want 0", bad[t], ps_o, sc_o);
      end
    end
  endtask

  task automatic test_random_stream(input int n);
    for (int c = 0; c < n; c++) begin
      x_i = rnd256(); y_i = rnd256(); mode_i = rnd_mode(); width_i = rnd_width();
      step();
      n_checks++;
      if (ps_o !== exp_ps || sc_o !== exp_sc) begin
        n_fail++;
        $display("FAIL stream_cyc%0d ps=%h sc=%h want ps=%h sc=%h", c, ps_o, sc_o, exp_ps, exp_sc);
      end
    end
  endtask

  task automatic test_reset_midstream();
    test_random_stream(40);
    #2 rst_i = 1'b1;
    #1;
    n_checks++;
    if (ps_o !== '0 || sc_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_async ps=%h sc=%h want 0", ps_o, sc_o);
    end
    repeat (2) begin
      x_i = rnd256(); y_i = rnd256(); mode_i = 3'b100; width_i = 3'b000;
      @(posedge clk_i);
      #1;
      n_checks++;
      if (ps_o !== '0 || sc_o !== '0) begin
        n_fail++;
        $display("FAIL midreset_hold ps=%h sc=%h want 0", ps_o, sc_o);
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    reset_model();
    n_checks++;
    if (ps_o !== '0 || sc_o !== '0) begin
      n_fail++;
      $display("FAIL midreset_release ps=%h sc=%h want 0", ps_o, sc_o);
    end
    for (int c = 0; c < 30; c++) begin
      x_i = rnd256(); y_i = rnd256(); mode_i = 3'b100; width_i = rnd_width();
      step();
      if (c < 8) begin
        n_checks++;
        if (ps_o !== '0 || sc_o !== '0) begin
          n_fail++;
          $display("FAIL post_reset_zero_cyc%0d ps=%h sc=%h want 0", c, ps_o, sc_o);
        end
      end
      n_checks++;
      if (ps_o !== exp_ps || sc_o !== exp_sc) begin
        n_fail++;
        $display("FAIL post_reset_cyc%0d ps=%h sc=%h want ps=%h sc=%h", c, ps_o, sc_o, exp_ps, exp_sc);
      end
    end
  endtask

  task automatic test_back_to_back();
    test_random_stream(3000);
  endtask

  initial begin
    test_reset();
    test_mode_a();
    test_mode_b();
    test_invalid_mode();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
